egd_wb_bitstream_feeder: RTL and testbench

//  Wishbone slave that sits upstream of egd_top_wrapper. Firmware writes 32-bit H.264 NAL words;

---
 rtl/egd_wb_bitstream_feeder.sv | 168 ++++++++++++++++
 tb/tb_egd_wb_bitstream_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/egd_wb_bitstream_feeder.sv
// Wishbone slave that buffers 32-bit NAL words in a FIFO and serialises them,
// high halfword first, onto the decoder's 16-bit valid/ready bitstream port.
module egd_wb_bitstream_feeder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LOW_WM    = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] bs_data_o,
  output logic        bs_valid_o,
  input  logic        bs_ready_i,
  output logic        dec_en_o,
  output logic        irq_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_WM_C = CW'(LOW_WM);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic          req;
  logic [1:0]    reg_sel;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic          ovf_clr;
  logic          ctrl_wr;
  logic          flush;
  logic          ovf;
  logic          full;
  logic          fifo_empty;
  logic          xfer;
  logic          lo_half;
  logic [15:0]   low_word;
  logic [31:0]   head;
  logic [31:0]   rd_data;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem [DEPTH];
  logic          unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // A request is a matching strobe while no ack is outstanding.
  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o
                  & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = wbs_adr_i[3:2];
  assign push_req = req & wbs_we_i & (reg_sel == REG_DATA) & (wbs_sel_i == 4'hF);
  assign ovf_clr  = req & wbs_we_i & (reg_sel == REG_STATUS) & wbs_dat_i[15];
  assign ctrl_wr  = req & wbs_we_i & (reg_sel == REG_CTRL);
  assign flush    = ctrl_wr & wbs_dat_i[0];

  assign fifo_empty = (count == '0);
  assign full       = (count == DEPTH_C);
  assign head       = mem[rd_ptr];
  assign xfer       = bs_valid_o & bs_ready_i;

  // Refill the serialiser when it is empty or its last halfword leaves this edge.
  assign pop  = ~flush & ~fifo_empty & (~bs_valid_o | (xfer & lo_half));
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: rd_data = {16'b0, ovf, full, fifo_empty, 6'b0, 7'(count)};
      REG_CTRL:   rd_data = {30'b0, dec_en_o, 1'b0};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dec_en_o <= 1'b0;
      ovf      <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        dec_en_o <= wbs_dat_i[1];
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      irq_o <= dec_en_o & (count <= LOW_WM_C) & ~full;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wbs_dat_i;
    end
  end

  // FIFO pointers and fill count; flush wins over a concurrent pop.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser: bs_data_o holds the live halfword, low_word the pending one.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bs_valid_o <= 1'b0;
      bs_data_o  <= '0;
      low_word   <= '0;
      lo_half    <= 1'b0;
    end else if (flush) begin
      bs_valid_o <= 1'b0;
      lo_half    <= 1'b0;
    end else if (pop) begin
      bs_data_o  <= head[31:16];
      low_word   <= head[15:0];
      bs_valid_o <= 1'b1;
      lo_half    <= 1'b0;
    end else if (xfer) begin
      if (lo_half) begin
        bs_valid_o <= 1'b0;
        lo_half    <= 1'b0;
      end else begin
        bs_data_o <= low_word;
        lo_half   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_egd_wb_bitstream_feeder.sv
// Bench for egd_wb_bitstream_feeder: register vector table plus halfword
// scoreboard filled on every accepted DATA write and drained by a monitor.
module tb_egd_wb_bitstream_feeder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_w = '0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [15:0] bs_data;
  logic        bs_valid;
  logic        bs_ready = 1'b0;
  logic        dec_en;
  logic        irq;

  logic        rand_ready = 1'b0;
  logic        ready_level = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_h;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[15];

  egd_wb_bitstream_feeder #(
    .BASE_ADDR(BASE), .DEPTH(8), .LOW_WM(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .bs_data_o(bs_data), .bs_valid_o(bs_valid), .bs_ready_i(bs_ready),
    .dec_en_o(dec_en), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bs_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Halfword monitor: order against the scoreboard, and hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bs_valid) check("bs_hold", 32'(bs_data), 32'(prev_data));
      if (bs_valid && bs_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL bs_extra: got 0x%04h, want no halfword", bs_data);
        end else begin
          exp_h = exp_q.pop_front();
          check("bs_order", 32'(bs_data), 32'(exp_h));
        end
      end
      prev_stall = bs_valid & ~bs_ready;
      prev_data  = bs_data;
    end
  end

  // One bus access from a cycle start; returns one idle cycle after the ack slot.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic got_ack, output logic [31:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    @(posedge clk); #1;
    got_ack = ack;
    rd      = dat_r;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reg_write(input string name, input logic [31:0] a, input logic [31:0] d);
    logic        k;
    logic [31:0] r;
    wb_xfer(1'b1, a, d, 4'hF, k, r);
    check(name, 32'(k), 32'd1);
  endtask

  task automatic reg_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic        k;
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'h0, 4'hF, k, r);
    check(name, r, exp);
  endtask

  task automatic push_word(input logic [31:0] w, input logic accepted);
    if (accepted) begin
      exp_q.push_back(w[31:16]);
      exp_q.push_back(w[15:0]);
    end
    reg_write("data_ack", BASE, w);
  endtask

  task automatic wait_drain(input int max_cyc);
    int c = 0;
    while ((exp_q.size() != 0 || bs_valid) && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_in_time", 32'(c < max_cyc), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        k;
    logic [31:0] r;
    logic [31:0] w;

    tbl[0]  = '{1'b0, BASE + 32'h4,  32'h0,         4'hF, 1'b1, 32'h0000_2000};
    tbl[1]  = '{1'b0, BASE + 32'h0,  32'h0,         4'hF, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, BASE + 32'h8,  32'h0,         4'hF, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, BASE + 32'hC,  32'h0,         4'hF, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, BASE + 32'hC,  32'h0,         4'hF, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, BASE + 32'h8,  32'h2,         4'hF, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, BASE + 32'h8,  32'h0,         4'hF, 1'b1, 32'h2};
    tbl[8]  = '{1'b1, BASE + 32'h8,  32'h0,         4'hF, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, BASE + 32'h0,  32'hDEAD_BEEF, 4'h3, 1'b1, 32'h0};
    tbl[10] = '{1'b0, BASE + 32'h4,  32'h0,         4'hF, 1'b1, 32'h0000_2000};
    tbl[11] = '{1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    tbl[12] = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[13] = '{1'b0, BASE + 32'h4,  32'h0,         4'hF, 1'b1, 32'h0000_2000};
    tbl[14] = '{1'b1, BASE + 32'h4,  32'h8000,      4'hF, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(bs_valid), 32'd0);
    check("rst_irq",   32'(irq),      32'd0);
    check("rst_ack",   32'(ack),      32'd0);
    check("rst_dec_en", 32'(dec_en),  32'd0);
    check("rst_data",  32'(bs_data),  32'd0);

    for (int i = 0; i < 15; i++) begin
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, k, r);
      check($sformatf("vec%0d_ack", i), 32'(k), 32'(tbl[i].ack));
      check($sformatf("vec%0d_rd", i), r, tbl[i].rd);
    end
    check("no_push_valid", 32'(bs_valid), 32'd0);

    // Latency from an empty feeder: write in T, halves in T+2 and T+3.
    ready_level = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_word(32'h1234_5678, 1'b1);
    check("lat_valid_t2", 32'(bs_valid), 32'd1);
    check("lat_data_t2",  32'(bs_data),  32'h1234);
    @(posedge clk); #1;
    check("lat_valid_t3", 32'(bs_valid), 32'd1);
    check("lat_data_t3",  32'(bs_data),  32'h5678);
    @(posedge clk); #1;
    check("lat_valid_t4", 32'(bs_valid), 32'd0);

    // Overflow: serialiser takes one word, FIFO takes eight, the tenth drops.
    ready_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) push_word(32'hA000_0000 + 32'(i * 32'h0001_0101), i < 9);
    reg_read("ovf_status", BASE + 32'h4, 32'h0000_C008);
    check("ovf_stall_data", 32'(bs_data), 32'hA000);
    reg_write("ovf_clr_ack", BASE + 32'h4, 32'h0000_8000);
    reg_read("ovf_cleared", BASE + 32'h4, 32'h0000_4008);
    ready_level = 1'b1;
    wait_drain(200);
    reg_read("drained_status", BASE + 32'h4, 32'h0000_2000);

    // Random backpressure on four queued words.
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      push_word(w, 1'b1);
    end
    wait_drain(400);
    rand_ready  = 1'b0;
    ready_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Flush with words queued; dec_en and the watermark interrupt survive it.
    reg_write("ctrl_en_ack", BASE + 32'h8, 32'h2);
    for (int i = 0; i < 3; i++) push_word(32'h5000_0000 + 32'(i), 1'b1);
    reg_read("pre_flush_status", BASE + 32'h4, 32'h0000_0002);
    check("irq_at_wm", 32'(irq), 32'd1);
    push_word(32'h5000_0003, 1'b1);
    check("irq_above_wm", 32'(irq), 32'd0);
    reg_write("flush_ack", BASE + 32'h8, 32'h3);
    exp_q.delete();
    check("flush_valid",  32'(bs_valid), 32'd0);
    check("flush_dec_en", 32'(dec_en),   32'd1);
    check("flush_irq",    32'(irq),      32'd1);
    reg_read("flush_status", BASE + 32'h4, 32'h0000_2000);
    reg_read("flush_ctrl",   BASE + 32'h8, 32'h0000_0002);
    reg_write("ctrl_off_ack", BASE + 32'h8, 32'h0);
    check("irq_disabled", 32'(irq), 32'd0);

    // Reset landing on a request edge suppresses the ack.
    push_word(32'h7777_8888, 1'b1);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack",   32'(ack),      32'd0);
    check("rst_mid_valid", 32'(bs_valid), 32'd0);
    stb = 1'b0; cyc = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    reg_read("post_rst_status", BASE + 32'h4, 32'h0000_2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
